// File: rtl/game_pkg.sv
// Shared game constants: cheese platform spot table, spawner state encoding, spot selection helper.
package game_pkg;

  localparam int N_SPOTS = 8;

  localparam logic [11:0] CHEESE_SPOT_X [0:N_SPOTS-1] = '{
    12'd40, 12'd120, 12'd200, 12'd280, 12'd360, 12'd440, 12'd520, 12'd600
  };

  localparam logic [11:0] CHEESE_SPOT_Y [0:N_SPOTS-1] = '{
    12'd400, 12'd320, 12'd400, 12'd240, 12'd320, 12'd160, 12'd400, 12'd240
  };

  typedef enum logic [2:0] {
    HIDDEN,
    PLACE,
    VISIBLE,
    RESPAWN,
    DONE
  } cheese_state_t;

  // A candidate equal to the current spot is bumped by one so the cheese always moves.
  function automatic logic [2:0] pick_spot(input logic [2:0] cand, input logic [2:0] cur);
    return (cand == cur) ? cand + 3'd1 : cand;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), advances every cycle, loads SEED on rst.
// Latency: new value each cycle; no backpressure.
module spawn_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

endmodule

// File: rtl/cheese_spawner.sv
// Cheese placement sequencer: pseudo-random spot, hide on take, respawn after N frames; CHEESE_TIMEOUT_EN adds relocation of an untaken cheese.
// Latency: start -> visible in 2 cycles; last respawn tick -> visible in 2 cycles; no backpressure.
module cheese_spawner
  import game_pkg::*;
#(
  parameter int         RESPAWN_FRAMES = 60,
  parameter int         TIMEOUT_FRAMES = 600,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        cheese_taken,
  input  logic        cheese_gm,
  output logic [11:0] cheese_x,
  output logic [11:0] cheese_y,
  output logic        cheese_visible,
  output logic [2:0]  spot_idx,
  output logic        round_done
);

  localparam logic [9:0] RESP_LAST = 10'(RESPAWN_FRAMES - 1);
  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT_FRAMES - 1);

  cheese_state_t state_q, state_d;
  logic [7:0]    lfsr;
  logic          lfsr_unused;
  logic [9:0]    resp_cnt;
  logic [2:0]    next_spot;
  logic          tmo_hit;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Only the low bits choose a spot.
  assign lfsr_unused = ^lfsr[7:3];
  assign next_spot   = pick_spot(lfsr[2:0], spot_idx);

`ifdef CHEESE_TIMEOUT_EN
  logic [9:0] tmo_cnt;

  assign tmo_hit = frame_tick && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst || reset || state_q != VISIBLE) begin
      tmo_cnt <= '0;
    end else if (frame_tick) begin
      tmo_cnt <= tmo_cnt + 10'd1;
    end
  end
`else
  logic tmo_cfg_unused;

  assign tmo_hit        = 1'b0;
  assign tmo_cfg_unused = ^TMO_LAST;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HIDDEN:  if (start) state_d = PLACE;
      PLACE:   state_d = VISIBLE;
      VISIBLE: begin
        if (cheese_taken && cheese_gm) state_d = DONE;
        else if (cheese_taken)         state_d = RESPAWN;
        else if (tmo_hit)              state_d = PLACE;
      end
      RESPAWN: if (frame_tick && resp_cnt == RESP_LAST) state_d = PLACE;
      DONE:    state_d = DONE;
      default: state_d = HIDDEN;
    endcase
    if (reset) state_d = HIDDEN;
  end

  always_ff @(posedge clk) begin
    if (rst || reset) begin
      state_q        <= HIDDEN;
      cheese_x       <= '0;
      cheese_y       <= '0;
      cheese_visible <= 1'b0;
      spot_idx       <= '0;
      round_done     <= 1'b0;
      resp_cnt       <= '0;
    end else begin
      state_q        <= state_d;
      // A timeout relocation passes through PLACE without blinking the cheese off.
      cheese_visible <= (state_d == VISIBLE) || (state_q == VISIBLE && state_d == PLACE);
      round_done     <= (state_d == DONE);
      if (state_q == PLACE) begin
        spot_idx <= next_spot;
        cheese_x <= CHEESE_SPOT_X[next_spot];
        cheese_y <= CHEESE_SPOT_Y[next_spot];
      end
      // Cleared while visible so a tick coincident with the take is not counted.
      if (state_q == VISIBLE) begin
        resp_cnt <= '0;
      end else if (state_q == RESPAWN && frame_tick) begin
        resp_cnt <= resp_cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_cheese_spawner.sv
// Directed-plus-random bench for cheese_spawner with a spot/LFSR reference model.
module tb_cheese_spawner;

  localparam int         RESP = 3;
  localparam int         TMO  = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic        cheese_taken = 1'b0;
  logic        cheese_gm = 1'b0;
  logic [11:0] cheese_x, cheese_y;
  logic        cheese_visible;
  logic [2:0]  spot_idx;
  logic        round_done;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] tx [8] = '{12'd40, 12'd120, 12'd200, 12'd280, 12'd360, 12'd440, 12'd520, 12'd600};
  logic [11:0] ty [8] = '{12'd400, 12'd320, 12'd400, 12'd240, 12'd320, 12'd160, 12'd400, 12'd240};

  logic [7:0] m_lfsr;
  logic [2:0] exp_spot;

  cheese_spawner #(
    .RESPAWN_FRAMES (RESP),
    .TIMEOUT_FRAMES (TMO),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .reset          (reset),
    .start          (start),
    .frame_tick     (frame_tick),
    .cheese_taken   (cheese_taken),
    .cheese_gm      (cheese_gm),
    .cheese_x       (cheese_x),
    .cheese_y       (cheese_y),
    .cheese_visible (cheese_visible),
    .spot_idx       (spot_idx),
    .round_done     (round_done)
  );

  always #5 clk = ~clk;

  // Polynomial x^8+x^6+x^5+x^4+1 in right-shifting Galois form.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 8'b1011_1000;
    return r;
  endfunction

  // Free-running reference LFSR; only rst reloads it.
  always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(negedge clk);
    start = 1'b0;
    frame_tick = 1'b0;
    cheese_taken = 1'b0;
    cheese_gm = 1'b0;
    reset = 1'b0;
  endtask

  // Fire the pulse that makes the next cycle a PLACE cycle; want>=0 waits for that candidate.
  task automatic trigger_place(input int want, input logic use_start);
    int         n;
    logic [7:0] nl;
    logic [2:0] cand, newspot;
    n  = 0;
    nl = lfsr_next(m_lfsr);
    while (want >= 0 && int'(nl[2:0]) != want && n < 300) begin
      tick_clk();
      n++;
      nl = lfsr_next(m_lfsr);
    end
    chk("place_wait_bound", n < 300, 1);
    cand    = nl[2:0];
    newspot = (cand == exp_spot) ? 3'((int'(cand) + 1) % 8) : cand;
    if (use_start) start = 1'b1;
    else           frame_tick = 1'b1;
    tick_clk();
    chk("place_cycle_hidden", cheese_visible, 0);
    tick_clk();
    chk("visible_after_place", cheese_visible, 1);
    chk("spot_idx", spot_idx, newspot);
    chk("cheese_x", cheese_x, tx[newspot]);
    chk("cheese_y", cheese_y, ty[newspot]);
    exp_spot = newspot;
  endtask

  task automatic respawn(input int want);
    logic [2:0] old;
    old = exp_spot;
    cheese_taken = 1'b1;
    frame_tick = 1'($urandom_range(0, 1));
    tick_clk();
    chk("taken_hides", cheese_visible, 0);
    chk("x_held_hidden", cheese_x, tx[old]);
    for (int i = 0; i < RESP - 1; i++) begin
      repeat ($urandom_range(0, 3)) begin
        start = 1'($urandom_range(0, 1));
        cheese_taken = 1'($urandom_range(0, 1));
        cheese_gm = cheese_taken & 1'($urandom_range(0, 1));
        tick_clk();
      end
      frame_tick = 1'b1;
      tick_clk();
      chk("respawn_hidden", cheese_visible, 0);
    end
    trigger_place(want, 1'b0);
    chk("spot_moved", spot_idx != old, 1);
  endtask

  initial begin
    logic [2:0] old;
    logic [7:0] nl;
    logic [2:0] cand;
    exp_spot = 3'd0;

    repeat (3) tick_clk();
    rst = 1'b0;
    chk("rst_x", cheese_x, 0);
    chk("rst_y", cheese_y, 0);
    chk("rst_visible", cheese_visible, 0);
    chk("rst_spot", spot_idx, 0);
    chk("rst_round_done", round_done, 0);

    // Inputs other than start are ignored while hidden.
    repeat (6) begin
      frame_tick = 1'($urandom_range(0, 1));
      cheese_taken = 1'($urandom_range(0, 1));
      cheese_gm = cheese_taken;
      tick_clk();
    end
    chk("hidden_ignores_visible", cheese_visible, 0);
    chk("hidden_ignores_done", round_done, 0);

    trigger_place(-1, 1'b1);

    repeat (6) respawn(-1);

`ifdef CHEESE_TIMEOUT_EN
    old = exp_spot;
    repeat (TMO - 1) begin
      repeat ($urandom_range(0, 2)) tick_clk();
      frame_tick = 1'b1;
      tick_clk();
      chk("pre_timeout_spot", spot_idx, old);
    end
    nl   = lfsr_next(m_lfsr);
    cand = nl[2:0];
    exp_spot = (cand == old) ? 3'((int'(cand) + 1) % 8) : cand;
    frame_tick = 1'b1;
    tick_clk();
    chk("timeout_place_visible", cheese_visible, 1);
    tick_clk();
    chk("timeout_spot", spot_idx, exp_spot);
    chk("timeout_visible", cheese_visible, 1);
    chk("timeout_x", cheese_x, tx[exp_spot]);
`else
    old = exp_spot;
    repeat (10) begin
      repeat ($urandom_range(0, 2)) tick_clk();
      frame_tick = 1'b1;
      tick_clk();
    end
    chk("no_timeout_spot", spot_idx, old);
    chk("no_timeout_visible", cheese_visible, 1);
`endif

    // Move to spot 7, then force a colliding candidate so it wraps to 0.
    if (exp_spot != 3'd7) respawn(7);
    respawn(7);
    chk("wrap_to_0", spot_idx, 0);

    // Game restart mid-respawn aborts with no residual frames.
    cheese_taken = 1'b1;
    tick_clk();
    frame_tick = 1'b1;
    tick_clk();
    reset = 1'b1;
    tick_clk();
    chk("abort_visible", cheese_visible, 0);
    chk("abort_spot", spot_idx, 0);
    chk("abort_x", cheese_x, 0);
    chk("abort_round_done", round_done, 0);
    exp_spot = 3'd0;
    repeat ($urandom_range(1, 5)) tick_clk();
    trigger_place(-1, 1'b1);

    // Goal reached: DONE latches until restart.
    old = exp_spot;
    cheese_taken = 1'b1;
    cheese_gm = 1'b1;
    tick_clk();
    chk("done_round_done", round_done, 1);
    chk("done_visible", cheese_visible, 0);
    start = 1'b1;
    tick_clk();
    repeat (5) begin
      frame_tick = 1'b1;
      tick_clk();
    end
    cheese_taken = 1'b1;
    tick_clk();
    chk("done_hold_round_done", round_done, 1);
    chk("done_hold_visible", cheese_visible, 0);
    chk("done_hold_spot", spot_idx, old);
    reset = 1'b1;
    tick_clk();
    chk("restart_round_done", round_done, 0);
    chk("restart_spot", spot_idx, 0);
    chk("restart_visible", cheese_visible, 0);
    chk("restart_y", cheese_y, 0);
    exp_spot = 3'd0;

    // LFSR keeps running across restart; a fresh round must follow the model.
    trigger_place(-1, 1'b1);
    respawn(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
